// File: rtl/mem_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef logic master_idx_t;
    localparam master_idx_t MST0 = 1'b0;
    localparam master_idx_t MST1 = 1'b1;

    localparam logic [31:0] ARB_ERR_DATA        = 32'hDEAD_BEEF;
    localparam int          ARB_TIMEOUT_DEFAULT = 1024;

    function automatic logic [1:0] grant_of(arb_state_t s);
        return {s == GRANT1, s == GRANT0};
    endfunction

endpackage

// File: rtl/mem_req_if.sv
// Simple read/write request bus; used both requester->arbiter and arbiter->memory.
interface mem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     rdata;
    logic                  resp;

    modport master (output read, write, addr, wdata, be, input  rdata, resp);
    modport slave  (input  read, write, addr, wdata, be, output rdata, resp);
endinterface

// File: rtl/rr_pick2.sv
// Stateless 2-way round-robin pick: on a tie, the master not served last wins.
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0]  i_pending,
    input  master_idx_t i_last_served,
    output logic        o_valid,
    output master_idx_t o_pick
);

    assign o_valid = |i_pending;

    always_comb begin
        // NOTE: assign a default first so every path drives o_pick and no latch is inferred.
        o_pick = MST0;
        if (i_pending == 2'b11) begin
            o_pick = ~i_last_served;
        end else if (i_pending[1]) begin
            o_pick = MST1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between two masters,
// one outstanding transaction at a time, with a watchdog abort.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = ARB_TIMEOUT_DEFAULT,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ARB_ERR_DATA)
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_req_if.slave   m0,
    mem_req_if.slave   m1,
    mem_req_if.master  mem,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    master_idx_t       r_last_served;
    logic [CNT_W-1:0]  r_wdog_cnt;
    logic              r_timeout_err;

    logic [1:0]          w_pending;
    logic                w_pick_valid;
    master_idx_t         w_pick;
    logic                w_in_grant;
    logic                w_timeout;
    logic                w_done;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_read;
    logic                w_write;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W/8-1:0] w_be;

    assign w_pending = {m1.read | m1.write, m0.read | m0.write};

    rr_pick2 u_pick (
        .i_pending     (w_pending),
        .i_last_served (r_last_served),
        .o_valid       (w_pick_valid),
        .o_pick        (w_pick)
    );

    // mem_resp arriving together with the last watchdog cycle counts as a normal completion.
    assign w_in_grant = (r_state == GRANT0) || (r_state == GRANT1);
    assign w_timeout  = w_in_grant && !mem.resp && (r_wdog_cnt == CNT_LAST);
    assign w_done     = w_in_grant && (mem.resp || w_timeout);
    assign w_rdata    = w_timeout ? ERR_DATA : mem.rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state       <= IDLE;
            r_last_served <= MST1;
            r_wdog_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= (w_pick == MST1) ? GRANT1 : GRANT0;
                        r_wdog_cnt <= '0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (w_done) begin
                        r_state       <= IDLE;
                        r_last_served <= (r_state == GRANT1) ? MST1 : MST0;
                        if (w_timeout) r_timeout_err <= 1'b1;
                    end else if (r_wdog_cnt != CNT_LAST) begin
                        r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The owner's live inputs go straight to the memory; a dropped request is not masked.
    always_comb begin
        w_read  = 1'b0;
        w_write = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        unique case (r_state)
            GRANT0: begin
                w_read  = m0.read;
                w_write = m0.write;
                w_addr  = m0.addr;
                w_wdata = m0.wdata;
                w_be    = m0.be;
            end
            GRANT1: begin
                w_read  = m1.read;
                w_write = m1.write;
                w_addr  = m1.addr;
                w_wdata = m1.wdata;
                w_be    = m1.be;
            end
            default: ;
        endcase
    end

    assign mem.read  = w_read;
    assign mem.write = w_write;
    assign mem.addr  = w_addr;
    assign mem.wdata = w_wdata;
    assign mem.be    = w_be;

    assign m0.resp  = w_done && (r_state == GRANT0);
    assign m1.resp  = w_done && (r_state == GRANT1);
    assign m0.rdata = m0.resp ? w_rdata : '0;
    assign m1.rdata = m1.resp ? w_rdata : '0;

    assign grant       = grant_of(r_state);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases, random vs. model.
module tb_mem_arbiter;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout_err;

    mem_req_if m0_if ();
    mem_req_if m1_if ();
    mem_req_if mem_if ();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .mem         (mem_if),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_if.read = 0; m0_if.write = 0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.be = '0;
        m1_if.read = 0; m1_if.write = 0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.be = '0;
        mem_if.resp = 0; mem_if.rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_resp", {m0_if.resp, m1_if.resp}, 2'b00);
        check("rst_mem_rw", {mem_if.read, mem_if.write}, 2'b00);
        check("rst_terr", timeout_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        m0_rd, m1_rd, mem_resp;
        logic [31:0] mem_rdata;
        logic [1:0]  exp_grant;
        logic        exp_r0, exp_r1, exp_mread;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(bit a, bit b, bit r, logic [31:0] d, logic [1:0] g,
                                bit e0, bit e1, bit emr, logic [31:0] ed);
        vec_t v;
        v.m0_rd = a; v.m1_rd = b; v.mem_resp = r; v.mem_rdata = d;
        v.exp_grant = g; v.exp_r0 = e0; v.exp_r1 = e1; v.exp_mread = emr; v.exp_rdata = ed;
        return v;
    endfunction

    // ---------------- random reference model ----------------
    typedef struct {
        bit          active;
        logic        rd, wr;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
    } req_t;

    req_t        rq[2];
    bit          got[2];
    int          owner, waited, last_srv, mem_lat, n;
    bit          terr, done, found;
    logic [1:0]  e_grant;
    logic        e_r0, e_r1;
    logic [31:0] e_rd;
    req_t        e_mem;

    task automatic drive_reqs();
        m0_if.read  = rq[0].active & rq[0].rd;  m0_if.write = rq[0].active & rq[0].wr;
        m0_if.addr  = rq[0].addr;  m0_if.wdata = rq[0].wdata;  m0_if.be = rq[0].be;
        m1_if.read  = rq[1].active & rq[1].rd;  m1_if.write = rq[1].active & rq[1].wr;
        m1_if.addr  = rq[1].addr;  m1_if.wdata = rq[1].wdata;  m1_if.be = rq[1].be;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Tie after reset goes to M0, then alternation with an IDLE cycle between grants;
        // then a single M0 read answered two cycles after mem_read; then a stray mem_resp.
        tbl[0]  = mk(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
        tbl[1]  = mk(1, 1, 1, 32'hA1A1_A1A1, 2'b01, 1, 0, 1, 32'hA1A1_A1A1);
        tbl[2]  = mk(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
        tbl[3]  = mk(1, 1, 1, 32'hB2B2_B2B2, 2'b10, 0, 1, 1, 32'hB2B2_B2B2);
        tbl[4]  = mk(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
        tbl[5]  = mk(1, 1, 1, 32'hC3C3_C3C3, 2'b01, 1, 0, 1, 32'hC3C3_C3C3);
        tbl[6]  = mk(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
        tbl[7]  = mk(1, 1, 1, 32'hD4D4_D4D4, 2'b10, 0, 1, 1, 32'hD4D4_D4D4);
        tbl[8]  = mk(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
        tbl[9]  = mk(1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
        tbl[10] = mk(1, 0, 0, 32'h0,         2'b01, 0, 0, 1, 32'h0);
        tbl[11] = mk(1, 0, 0, 32'h0,         2'b01, 0, 0, 1, 32'h0);
        tbl[12] = mk(1, 0, 1, 32'h1234_5678, 2'b01, 1, 0, 1, 32'h1234_5678);
        tbl[13] = mk(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0);
        tbl[14] = mk(0, 0, 1, 32'h5A5A_5A5A, 2'b00, 0, 0, 0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            m0_if.read = tbl[i].m0_rd;  m0_if.addr = 32'h0000_0010;
            m1_if.read = tbl[i].m1_rd;  m1_if.addr = 32'h0000_0100;
            mem_if.resp = tbl[i].mem_resp;  mem_if.rdata = tbl[i].mem_rdata;
            @(negedge clk);
            check($sformatf("vec%0d_grant", i), grant, tbl[i].exp_grant);
            check($sformatf("vec%0d_resp", i), {m0_if.resp, m1_if.resp}, {tbl[i].exp_r0, tbl[i].exp_r1});
            check($sformatf("vec%0d_mem_read", i), mem_if.read, tbl[i].exp_mread);
            check($sformatf("vec%0d_mem_addr", i), mem_if.addr,
                  tbl[i].exp_grant == 2'b01 ? 32'h10 : tbl[i].exp_grant == 2'b10 ? 32'h100 : 32'h0);
            check($sformatf("vec%0d_rdata0", i), m0_if.rdata, tbl[i].exp_r0 ? tbl[i].exp_rdata : 32'h0);
            check($sformatf("vec%0d_rdata1", i), m1_if.rdata, tbl[i].exp_r1 ? tbl[i].exp_rdata : 32'h0);
            tick();
        end
        clear_inputs();

        // M1 byte-masked write
        m1_if.write = 1; m1_if.addr = 32'h0000_0100; m1_if.wdata = 32'hCAFE_F00D; m1_if.be = 4'b0011;
        @(negedge clk);
        check("wr_idle_grant", grant, 2'b00);
        tick();
        @(negedge clk);
        check("wr_grant", grant, 2'b10);
        check("wr_mem_rw", {mem_if.read, mem_if.write}, 2'b01);
        check("wr_mem_addr", mem_if.addr, 32'h0000_0100);
        check("wr_mem_wdata", mem_if.wdata, 32'hCAFE_F00D);
        check("wr_mem_be", mem_if.be, 4'b0011);
        tick();
        mem_if.resp = 1;
        @(negedge clk);
        check("wr_resp", {m0_if.resp, m1_if.resp}, 2'b01);
        tick();
        clear_inputs();

        // Watchdog: memory never answers an M0 read
        m0_if.read = 1; m0_if.addr = 32'h0000_0020;
        n = 0; found = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            if (m0_if.resp) found = 1;
            else begin tick(); n++; end
        end
        check("to_latency", n, TO);
        check("to_rdata", m0_if.rdata, ERR);
        check("to_err_before", timeout_err, 1'b0);
        tick();
        m0_if.read = 0;
        @(negedge clk);
        check("to_err_set", timeout_err, 1'b1);
        check("to_idle_rw", {mem_if.read, mem_if.write}, 2'b00);
        tick();
        m1_if.read = 1; m1_if.addr = 32'h0000_0100;
        @(negedge clk);
        tick();
        mem_if.resp = 1; mem_if.rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("after_to_grant", grant, 2'b10);
        check("after_to_resp", {m0_if.resp, m1_if.resp}, 2'b01);
        check("after_to_rdata", m1_if.rdata, 32'h0BAD_F00D);
        tick();
        clear_inputs();
        @(negedge clk);
        check("to_err_sticky", timeout_err, 1'b1);
        tick();

        // Asynchronous reset in the middle of a GRANT1 transaction
        m1_if.read = 1; m1_if.addr = 32'h0000_0100;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("mid_grant1", grant, 2'b10);
        #2;
        mem_if.resp = 1; mem_if.rdata = 32'h1111_2222;
        rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 2'b00);
        check("arst_resp", {m0_if.resp, m1_if.resp}, 2'b00);
        check("arst_rdata1", m1_if.rdata, 32'h0);
        check("arst_mem_rw", {mem_if.read, mem_if.write}, 2'b00);
        check("arst_mem_addr", mem_if.addr, 32'h0);
        check("arst_terr", timeout_err, 1'b0);
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        mem_if.resp = 1; mem_if.rdata = 32'h3333_4444;
        @(negedge clk);
        check("stray_resp", {m0_if.resp, m1_if.resp}, 2'b00);
        check("stray_rdata", {m0_if.rdata, m1_if.rdata}, 64'h0);
        tick();
        mem_if.resp = 0;
        m0_if.read = 1; m1_if.read = 1;
        @(negedge clk);
        tick();
        mem_if.resp = 1; mem_if.rdata = 32'h5555_6666;
        @(negedge clk);
        check("post_rst_tie", grant, 2'b01);
        check("post_rst_resp", {m0_if.resp, m1_if.resp}, 2'b10);
        tick();
        clear_inputs();

        // Random traffic against the transaction-level model
        do_reset();
        owner = -1; waited = 0; last_srv = 1; terr = 0; mem_lat = 0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = '{active: 0, rd: 0, wr: 0, addr: '0, wdata: '0, be: '0};
            got[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (got[i]) rq[i].active = 0;
                got[i] = 0;
                if (!rq[i].active && $urandom_range(0, 2) != 0) begin
                    rq[i].active = 1;
                    rq[i].rd     = 1'($urandom_range(0, 1));
                    rq[i].wr     = !rq[i].rd;
                    rq[i].addr   = $urandom;
                    rq[i].wdata  = $urandom;
                    rq[i].be     = 4'($urandom_range(0, 15));
                end
            end
            drive_reqs();
            mem_if.rdata = $urandom;
            if (owner >= 0) mem_if.resp = (waited == mem_lat);
            else            mem_if.resp = ($urandom_range(0, 7) == 0);

            e_grant = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
            done    = (owner >= 0) && (mem_if.resp || waited == TO - 1);
            e_r0    = done && owner == 0;
            e_r1    = done && owner == 1;
            e_rd    = mem_if.resp ? mem_if.rdata : ERR;
            if (owner >= 0) begin
                e_mem = rq[owner];
            end else begin
                e_mem = '{active: 0, rd: 0, wr: 0, addr: '0, wdata: '0, be: '0};
            end

            @(negedge clk);
            check("rnd_grant", grant, e_grant);
            check("rnd_resp", {m0_if.resp, m1_if.resp}, {e_r0, e_r1});
            check("rnd_rdata0", m0_if.rdata, e_r0 ? e_rd : 32'h0);
            check("rnd_rdata1", m1_if.rdata, e_r1 ? e_rd : 32'h0);
            check("rnd_mem_rw", {mem_if.read, mem_if.write}, {e_mem.rd, e_mem.wr});
            check("rnd_mem_addr", mem_if.addr, e_mem.addr);
            check("rnd_mem_wdata", mem_if.wdata, e_mem.wdata);
            check("rnd_mem_be", mem_if.be, e_mem.be);
            check("rnd_terr", timeout_err, terr);

            if (owner < 0) begin
                if (rq[0].active && rq[1].active) owner = 1 - last_srv;
                else if (rq[0].active)            owner = 0;
                else if (rq[1].active)            owner = 1;
                if (owner >= 0) begin
                    waited  = 0;
                    mem_lat = $urandom_range(0, 20);
                end
            end else if (done) begin
                got[owner] = 1;
                last_srv   = owner;
                if (!mem_if.resp) terr = 1;
                owner = -1;
            end else begin
                waited++;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
